// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: format codes and shared types for the immediate encoder.
// Exports EXT_* format selects; anything else is an illegal op.
package imm_encoder_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] EXT_I = 3'd0;
    localparam logic [OP_W-1:0] EXT_S = 3'd1;
    localparam logic [OP_W-1:0] EXT_B = 3'd2;
    localparam logic [OP_W-1:0] EXT_U = 3'd3;
    localparam logic [OP_W-1:0] EXT_J = 3'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } pack_t;

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/result valid-ready bundle of the immediate encoder.
// master = requester/consumer side, slave = encoder side.
interface imm_encoder_if
    import imm_encoder_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [31:0]      in_imm;
    logic [31:0]      in_base;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_imm, in_base, in_tag, out_ready,
        input  in_ready, out_valid, out_inst, out_err, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_imm, in_base, in_tag, out_ready,
        output in_ready, out_valid, out_inst, out_err, out_tag
    );
endinterface

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational packer, {op,imm,base} -> {inst,err}.
// Ports: op/imm/base in; inst = base with immediate fields replaced, err out.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     imm,
    input  logic [31:0]     base,
    output logic [31:0]     inst,
    output logic            err
);

    always_comb begin
        inst = base;
        err  = 1'b0;
        unique case (1'b1)
            (op == EXT_I): begin
                inst[31:20] = imm[11:0];
                err = (imm[31:11] != {21{imm[11]}});
            end
            (op == EXT_S): begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                err = (imm[31:11] != {21{imm[11]}});
            end
            (op == EXT_B): begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                err = imm[0] | (imm[31:12] != {20{imm[12]}});
            end
            (op == EXT_U): begin
                inst[31:12] = imm[31:12];
                err = (imm[11:0] != 12'd0);
            end
            (op == EXT_J): begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                err = imm[0] | (imm[31:20] != {12{imm[20]}});
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: 2-stage valid/ready pipeline around imm_pack.
// Ports: clk, rst (async high), flush, bus (slave), err_cnt with IMM_ENC_ERRCNT_EN.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int TAG_W = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    imm_encoder_if.slave bus
`ifdef IMM_ENC_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    pack_t            pk;

    logic             s1_valid_q, s1_valid_d;
    pack_t            s1_data_q, s1_data_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    pack_t            s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic s1_adv, s2_adv, accept, move;

    imm_pack u_pack (
        .op   (bus.in_op),
        .imm  (bus.in_imm),
        .base (bus.in_base),
        .inst (pk.inst),
        .err  (pk.err)
    );

    assign s2_adv = !s2_valid_q | bus.out_ready;
    assign s1_adv = !s1_valid_q | s2_adv;
    assign accept = bus.in_valid & s1_adv;
    assign move   = s1_valid_q & s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
        end
        if (accept) begin
            s1_data_d = pk;
            s1_tag_d  = bus.in_tag;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (move) begin
            s2_data_d = s1_data_q;
            s2_tag_d  = s1_tag_q;
        end
        // Data may still load; only the valids matter once flushed.
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_inst  = s2_data_q.inst;
    assign bus.out_err   = s2_data_q.err;
    assign bus.out_tag   = s2_tag_q;

`ifdef IMM_ENC_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_valid_q && bus.out_ready && s2_data_q.err
            && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
